uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive control unit for the configurable UART receiver. It detects start bits on the serial line, drives the bit timer's `enable_timer`, and assembles data bits on the timer's `shift_enable` pulses. It validates the stop bit and presents the received word through a ready/read handshake with framing and overrun flags. It sits between the serial pad and the host-side register interface, with the bit timer as its sequenced datapath.

## Interface
Parameters:
- `MAX_BITS`, 8: width of `rx_data` and the largest accepted data size.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `serial_in`  in  1: asynchronous serial line; idles high.
- `data_size`  in  4: data bits per frame. 0 maps to 8, and values above `MAX_BITS` clamp to `MAX_BITS`. Latched at start-bit detection.
- `shift_enable`  in  1: one-cycle sample pulse from the bit timer.
- `packet_done`  in  1: level from the bit timer; rises the cycle after the final (stop-bit) `shift_enable` pulse.
- `data_read`  in  1: host acknowledge of `rx_data`.
- `enable_timer`  out  1: runs the bit timer; deasserting it clears the timer.
- `rx_data`  out  MAX_BITS: last accepted word, LSB-first assembly, upper unused bits 0.
- `data_ready`  out  1: `rx_data` holds an unread word.
- `framing_error`  out  1: last frame had stop bit = 0.
- `overrun_error`  out  1: a word was overwritten before being read.

## Operation
- **Synchronizer:** `serial_in` passes through two flops (s1, s2), plus a history flop p holding the previous s2. All three reset to 1.
- **Start detect:** `start = p & !s2`. Only a high-to-low transition counts. A line held low never triggers.
- **FSM states:** IDLE, RECEIVE, CHECK.
  - **IDLE:** `enable_timer` = 0. On `start`: go to RECEIVE, latch effective size N, clear bit index, clear `framing_error`.
  - **RECEIVE:** `enable_timer` = 1.
    - Each `shift_enable` with index < N: write s2 into `shift_reg[index]`, then index++.
    - A `shift_enable` with index == N: capture s2 as `stop_bit`.
    - `packet_done` = 1: go to CHECK.
  - **CHECK:** `enable_timer` = 0, then go to IDLE on the next edge.
    - If `stop_bit` = 1: `rx_data` ← `shift_reg` with bits ≥ N zeroed, and `data_ready` ← 1.
    - If `stop_bit` = 0: `framing_error` ← 1; `rx_data` and `data_ready` are unchanged.
- **Handshake:**
  - `data_read` while `data_ready` = 1 clears `data_ready` and `overrun_error` on the next edge.
  - `data_read` while `data_ready` = 0 is ignored.
- **Overrun:** a load while `data_ready` = 1 and `data_read` = 0 sets `overrun_error` and overwrites `rx_data`.
- **Load coincident with `data_read`:** new data is loaded, `data_ready` stays 1, no overrun.
- **Extra pulses:** `shift_enable` pulses after index N in the same frame are ignored.
- **Reset:** any state goes to IDLE. All outputs are 0, `rx_data` = 0, and index, `shift_reg` and `stop_bit` = 0.
  - Reset mid-frame drops `enable_timer` on the next edge and discards the partial word.

## Timing
- All outputs are registered or Moore-decoded from state; there are no combinational paths from inputs to outputs.
- Let E0 be the first edge that samples `serial_in` = 0 after it was high. Then:
  - s2 = 0 after E1, so `start` is true in the cycle after E1.
  - The state is RECEIVE after E2, and `enable_timer` = 1 from E2.
- Let P be the first edge at which `packet_done` = 1 is sampled. Then:
  - The state is CHECK after P, and `enable_timer` = 0 from P.
  - `data_ready`, `rx_data` and the error flags update at P+1.
  - The state is IDLE after P+1.
- A start edge detected in the cycle after P+1 is accepted. Edges during RECEIVE and CHECK are not tracked.
- `data_ready` falls one edge after `data_read` is sampled high.

## Test plan
Bench conditions: bit timer instantiated with `bit_period` = 10, and the serial driver times each bit to the timer's `shift_enable` pulses.

- **Reset during RECEIVE:** assert `rst` for 2 cycles partway through a frame → `enable_timer` = 0 and all outputs = 0 on the next edge, state IDLE. A following clean frame 0x3C is received correctly.
- **8-bit frame:** `data_size` = 0, frame 0xA5 (LSB first), stop = 1 → at P+1, `rx_data` = 0xA5, `data_ready` = 1, both error flags 0. Then `data_read` for 1 cycle → `data_ready` = 0 on the next edge.
- **Width handling:**
  - `data_size` = 5, data bits 1,0,1,1,0 → `rx_data` = 0x0D.
  - `data_size` = 12, frame 0xFF → `rx_data` = 0xFF, and exactly 9 `shift_enable` pulses are consumed before `packet_done`.
- **Bad stop bit:** after 0xA5 is held unread, send frame 0x11 with stop = 0 → `framing_error` = 1, `rx_data` stays 0xA5, `data_ready` stays 1. The next start edge clears `framing_error`.
- **Overrun:**
  - Two frames 0x12 then 0x34 with no read → `overrun_error` = 1, `rx_data` = 0x34.
  - Repeat with `data_read` asserted exactly at P+1 of the second frame → `overrun_error` = 0, `data_ready` = 1.
- **Low line at reset:** hold `serial_in` = 0 through reset release for 50 cycles → `enable_timer` stays 0. Raise `serial_in` for 3 cycles, then drop it → `enable_timer` = 1 at E2.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive control: start-bit detection, LSB-first assembly on bit-timer
// pulses, stop-bit validation and a ready/read handshake with error flags.
module uart_rx_ctrl #(
    parameter int MAX_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic [3:0]          data_size,
    input  logic                shift_enable,
    input  logic                packet_done,
    input  logic                data_read,
    output logic                enable_timer,
    output logic [MAX_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                framing_error,
    output logic                overrun_error
);
    localparam int IDX_W = $clog2(MAX_BITS + 2);

    typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_s1, r_s2, r_p;
    logic                r_live, r_seen_high;
    logic [IDX_W-1:0]    r_size, r_idx;
    logic [MAX_BITS-1:0] r_shift, r_rx_data;
    logic                r_stop, r_ready, r_fe, r_ovr;
    logic                w_start, w_load;

    function automatic logic [IDX_W-1:0] eff_size(input logic [3:0] sz);
        int n;
        n = (sz == 4'd0) ? 8 : int'(sz);
        if (n > MAX_BITS) n = MAX_BITS;
        return IDX_W'(n);
    endfunction

    function automatic logic [MAX_BITS-1:0] keep_low(input logic [MAX_BITS-1:0] v,
                                                     input logic [IDX_W-1:0]    n);
        logic [MAX_BITS-1:0] m;
        for (int i = 0; i < MAX_BITS; i++) m[i] = v[i] & (i < int'(n));
        return m;
    endfunction

    // The flops reset to 1, so a line already low at reset release would look
    // like a falling edge; r_seen_high requires one genuine high sample first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= 1'b1;
            r_s2        <= 1'b1;
            r_p         <= 1'b1;
            r_live      <= 1'b0;
            r_seen_high <= 1'b0;
        end else begin
            r_s1        <= serial_in;
            r_s2        <= r_s1;
            r_p         <= r_s2;
            r_live      <= 1'b1;
            r_seen_high <= r_seen_high | (r_live & r_s1);
        end
    end

    assign w_start = r_p & ~r_s2 & r_seen_high;
    assign w_load  = (r_state == CHECK) & r_stop;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        enable_timer = 1'b0;
        case (r_state)
            IDLE:    if (w_start) w_next = RECEIVE;
            RECEIVE: begin
                enable_timer = 1'b1;
                if (packet_done) w_next = CHECK;
            end
            CHECK:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_size    <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_stop    <= 1'b0;
            r_rx_data <= '0;
            r_ready   <= 1'b0;
            r_fe      <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_size <= eff_size(data_size);
                    r_idx  <= '0;
                    r_stop <= 1'b0;
                end
                RECEIVE: if (shift_enable) begin
                    // Index runs one past N after the stop sample so extra pulses are ignored.
                    if (r_idx < r_size) begin
                        for (int i = 0; i < MAX_BITS; i++)
                            if (r_idx == IDX_W'(i)) r_shift[i] <= r_s2;
                        r_idx <= r_idx + 1'b1;
                    end else if (r_idx == r_size) begin
                        r_stop <= r_s2;
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_load) begin
                r_rx_data <= keep_low(r_shift, r_size);
                r_ready   <= 1'b1;
                if (r_ready && !data_read)     r_ovr <= 1'b1;
                else if (r_ready && data_read) r_ovr <= 1'b0;
            end else if (r_ready && data_read) begin
                r_ready <= 1'b0;
                r_ovr   <= 1'b0;
            end

            if (r_state == IDLE && w_start)       r_fe <= 1'b0;
            else if (r_state == CHECK && !r_stop) r_fe <= 1'b1;
        end
    end

    assign rx_data       = r_rx_data;
    assign data_ready    = r_ready;
    assign framing_error = r_fe;
    assign overrun_error = r_ovr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models the bit timer (period 10), drives serial frames
// and compares outputs with a frame-level reference model.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [3:0] data_size;
    logic       shift_enable;
    logic       packet_done;
    logic       data_read;
    logic       enable_timer;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;

    int n_checks = 0;
    int n_errors = 0;

    int   tb_bits = 9;
    int   tcnt;
    int   npulse;
    int   pulse_cnt;
    logic en_q;

    logic [7:0]  m_rx;
    logic        m_ready, m_fe, m_ovr;
    int          sz, n;
    logic [15:0] d;
    logic        stp, rdb, rdl, en_bad;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.MAX_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .data_size    (data_size),
        .shift_enable (shift_enable),
        .packet_done  (packet_done),
        .data_read    (data_read),
        .enable_timer (enable_timer),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );

    // Bit timer: first sample pulse 15 counts into the frame, then every 10;
    // packet_done rises the cycle after the stop-bit pulse.
    always @(posedge clk) begin
        if (!enable_timer) begin
            tcnt         <= 0;
            npulse       <= 0;
            shift_enable <= 1'b0;
            packet_done  <= 1'b0;
        end else begin
            tcnt <= tcnt + 1;
            if (tcnt >= 14 && (tcnt % 10) == 4 && npulse < tb_bits) begin
                shift_enable <= 1'b1;
                npulse       <= npulse + 1;
            end else begin
                shift_enable <= 1'b0;
            end
            if (shift_enable && npulse == tb_bits) packet_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        en_q <= enable_timer;
        if (enable_timer && !en_q) pulse_cnt <= 0;
        else if (shift_enable)     pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] erx, input logic erdy,
                             input logic efe, input logic eovr);
        chk({tag, " rx_data"}, 32'(rx_data), 32'(erx));
        chk({tag, " data_ready"}, 32'(data_ready), 32'(erdy));
        chk({tag, " framing"}, 32'(framing_error), 32'(efe));
        chk({tag, " overrun"}, 32'(overrun_error), 32'(eovr));
    endtask

    // Called and returns one time unit after a rising edge; returns at P.
    task automatic send_frame(input logic [15:0] data, input int nbits, input logic stop);
        serial_in = 1'b0;
        idle(10);
        chk("enable_in_frame", 32'(enable_timer), 1);
        chk("framing_cleared_at_start", 32'(framing_error), 0);
        for (int i = 0; i < nbits; i++) begin
            serial_in = data[i];
            idle(10);
        end
        serial_in = stop;
        idle(10);
        serial_in = 1'b1;
        chk("enable_dropped_at_P", 32'(enable_timer), 0);
    endtask

    task automatic read_pulse();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
    endtask

    function automatic int eff_n(input int s);
        if (s == 0) return 8;
        return (s > 8) ? 8 : s;
    endfunction

    initial begin
        rst       = 1'b1;
        serial_in = 1'b1;
        data_size = 4'd0;
        data_read = 1'b0;
        idle(3);
        chk("reset enable", 32'(enable_timer), 0);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(3);

        // Reset partway through a frame, then a clean 0x3C.
        tb_bits   = 9;
        serial_in = 1'b0;
        idle(10);
        serial_in = 1'b1;
        idle(15);
        chk("midframe enable", 32'(enable_timer), 1);
        rst = 1'b1;
        tick();
        chk("midframe reset enable", 32'(enable_timer), 0);
        check_out("midframe reset", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        idle(5);
        send_frame(16'h003C, 8, 1'b1);
        tick();
        check_out("after reset 3C", 8'h3C, 1'b1, 1'b0, 1'b0);
        read_pulse();
        chk("3C read clears ready", 32'(data_ready), 0);

        // 8-bit frame with data_size = 0.
        idle(4);
        send_frame(16'h00A5, 8, 1'b1);
        chk("A5 not ready before P+1", 32'(data_ready), 0);
        tick();
        check_out("A5", 8'hA5, 1'b1, 1'b0, 1'b0);
        read_pulse();
        chk("A5 read clears ready", 32'(data_ready), 0);

        // Five-bit frame: bits 1,0,1,1,0.
        idle(4);
        data_size = 4'd5;
        tb_bits   = 6;
        send_frame(16'b01101, 5, 1'b1);
        tick();
        check_out("size5", 8'h0D, 1'b1, 1'b0, 1'b0);
        read_pulse();

        // Oversized data_size clamps to 8.
        idle(4);
        data_size = 4'd12;
        tb_bits   = 9;
        send_frame(16'h00FF, 8, 1'b1);
        tick();
        check_out("size12", 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("size12 pulse count", 32'(pulse_cnt), 9);
        read_pulse();

        // Bad stop bit while 0xA5 is held unread.
        data_size = 4'd0;
        idle(4);
        send_frame(16'h00A5, 8, 1'b1);
        tick();
        idle(4);
        send_frame(16'h0011, 8, 1'b0);
        tick();
        check_out("bad stop", 8'hA5, 1'b1, 1'b1, 1'b0);
        read_pulse();

        // Overrun: 0x12 then 0x34 with no read.
        idle(4);
        send_frame(16'h0012, 8, 1'b1);
        tick();
        check_out("ovr first", 8'h12, 1'b1, 1'b0, 1'b0);
        idle(4);
        send_frame(16'h0034, 8, 1'b1);
        tick();
        check_out("ovr second", 8'h34, 1'b1, 1'b0, 1'b1);
        read_pulse();
        check_out("ovr read", 8'h34, 1'b0, 1'b0, 1'b0);

        // Same pair, read coincident with the second load.
        idle(4);
        send_frame(16'h0012, 8, 1'b1);
        tick();
        idle(4);
        send_frame(16'h0034, 8, 1'b1);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        check_out("read at load", 8'h34, 1'b1, 1'b0, 1'b0);
        read_pulse();

        // Randomized frames against the reference model.
        m_rx = 8'h34; m_ready = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        for (int f = 0; f < 12; f++) begin
            sz  = int'($urandom_range(0, 15));
            n   = eff_n(sz);
            d   = 16'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            rdb = 1'($urandom_range(0, 1));
            rdl = 1'($urandom_range(0, 1));
            if (rdb) begin
                read_pulse();
                if (m_ready) begin m_ready = 1'b0; m_ovr = 1'b0; end
                chk("rnd read", 32'(data_ready), 32'(m_ready));
            end
            idle(int'($urandom_range(3, 8)));
            data_size = 4'(sz);
            tb_bits   = n + 1;
            send_frame(d, n, stp);
            m_fe = 1'b0;
            data_read = rdl;
            tick();
            data_read = 1'b0;
            if (stp) begin
                if (m_ready && !rdl)     m_ovr = 1'b1;
                else if (m_ready && rdl) m_ovr = 1'b0;
                m_rx    = 8'(32'(d) & ((1 << n) - 1));
                m_ready = 1'b1;
            end else begin
                m_fe = 1'b1;
                if (m_ready && rdl) begin m_ready = 1'b0; m_ovr = 1'b0; end
            end
            check_out($sformatf("rnd%0d", f), m_rx, m_ready, m_fe, m_ovr);
        end

        // Line held low through reset release never starts a frame.
        rst       = 1'b1;
        serial_in = 1'b0;
        data_size = 4'd0;
        tb_bits   = 9;
        idle(3);
        rst    = 1'b0;
        en_bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (enable_timer) en_bad = 1'b1;
        end
        chk("low line no start", 32'(en_bad), 0);
        serial_in = 1'b1;
        idle(3);
        serial_in = 1'b0;
        idle(2);
        chk("low line before E2", 32'(enable_timer), 0);
        tick();
        chk("low line enable at E2", 32'(enable_timer), 1);
        rst       = 1'b1;
        serial_in = 1'b1;
        idle(2);
        rst = 1'b0;
        tick();
        chk("final reset enable", 32'(enable_timer), 0);
        check_out("final reset", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
